// File: rtl/spi_ram_arbiter.sv
// rtl/spi_ram_arbiter.sv - multi-port SPI slave with mailboxes and a round-robin serial RAM arbiter
// Optional grant timeout: define SPI_RAM_ARBITER_TIMEOUT_EN.
module spi_ram_arbiter #(
   parameter int NUM_PORTS   = 2,
   parameter int BYTE_WIDTH  = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NUM_PORTS-1:0] port_nss,
   input  logic [NUM_PORTS-1:0] port_sck,
   input  logic [NUM_PORTS-1:0] port_mosi,
   output logic [NUM_PORTS-1:0] port_miso,
   output logic [NUM_PORTS-1:0] port_wait,
   output logic                 ram_nss,
   output logic                 ram_sck,
   output logic                 ram_mosi,
   input  logic                 ram_miso,
   output logic [NUM_PORTS-1:0] timeout_flag
);

   localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
   localparam int CNT_W = (BYTE_WIDTH > 2) ? $clog2(BYTE_WIDTH) : 1;
   localparam logic [BYTE_WIDTH-1:0] OP_READ  = BYTE_WIDTH'(1);
   localparam logic [BYTE_WIDTH-1:0] OP_WRITE = BYTE_WIDTH'(2);
   localparam logic [BYTE_WIDTH-1:0] OP_RAM   = BYTE_WIDTH'(3);

   typedef enum logic [2:0] {
      M_OPCODE = 3'd0,
      M_READ   = 3'd1,
      M_WRITE  = 3'd2,
      M_RAM    = 3'd3,
      M_IGNORE = 3'd4
   } mode_t;

   // synchronizer pipelines, one vector per stage covering all ports
   logic [NUM_PORTS-1:0]  nss_pipe  [SYNC_STAGES];
   logic [NUM_PORTS-1:0]  sck_pipe  [SYNC_STAGES];
   logic [NUM_PORTS-1:0]  mosi_pipe [SYNC_STAGES];
   logic [NUM_PORTS-1:0]  sck_q;
   logic [NUM_PORTS-1:0]  s_nss, s_sck, s_mosi, sck_rise, sck_fall;

   // per-port frame state
   mode_t                 mode      [NUM_PORTS];
   mode_t                 mode_nxt  [NUM_PORTS];
   logic [CNT_W-1:0]      bit_cnt   [NUM_PORTS];
   logic [BYTE_WIDTH-2:0] shift_in  [NUM_PORTS];
   logic [BYTE_WIDTH-1:0] tx_shift  [NUM_PORTS];
   logic [BYTE_WIDTH-1:0] mailbox   [NUM_PORTS];
   logic [BYTE_WIDTH-1:0] rx_byte   [NUM_PORTS];
   logic [NUM_PORTS-1:0]  armed, request;
   logic [NUM_PORTS-1:0]  rx_en, byte_done, op_done, req_set;

   // arbiter state
   logic [NUM_PORTS-1:0]  grant, grant_nxt, req_eff;
   logic [IDX_W-1:0]      ptr, ptr_nxt;
   logic                  keep, found;
   logic                  tmo_fire;

   assign s_nss    = nss_pipe[SYNC_STAGES-1];
   assign s_sck    = sck_pipe[SYNC_STAGES-1];
   assign s_mosi   = mosi_pipe[SYNC_STAGES-1];
   assign sck_rise = s_sck & ~sck_q;
   assign sck_fall = ~s_sck & sck_q;
   assign port_wait = request & ~grant;

   // bring the SPI pins into the clk domain; nss resets low so a port must show idle before it is armed
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < SYNC_STAGES; k++) begin
            nss_pipe[k]  <= '0;
            sck_pipe[k]  <= '0;
            mosi_pipe[k] <= '0;
         end
         sck_q <= '0;
      end else begin
         nss_pipe[0]  <= port_nss;
         sck_pipe[0]  <= port_sck;
         mosi_pipe[0] <= port_mosi;
         for (int k = 1; k < SYNC_STAGES; k++) begin
            nss_pipe[k]  <= nss_pipe[k-1];
            sck_pipe[k]  <= sck_pipe[k-1];
            mosi_pipe[k] <= mosi_pipe[k-1];
         end
         sck_q <= s_sck;
      end
   end

   // per-port byte framing and opcode decode into the next frame mode
   always_comb begin
      for (int i = 0; i < NUM_PORTS; i++) begin
         rx_en[i]     = armed[i] & ~s_nss[i] & (mode[i] != M_IGNORE);
         rx_byte[i]   = {shift_in[i], s_mosi[i]};
         byte_done[i] = rx_en[i] & sck_rise[i] & (bit_cnt[i] == CNT_W'(BYTE_WIDTH-1));
         op_done[i]   = byte_done[i] & (mode[i] == M_OPCODE);
         req_set[i]   = op_done[i] & (rx_byte[i] == OP_RAM);
         mode_nxt[i]  = mode[i];
         if (s_nss[i] || !armed[i]) begin
            mode_nxt[i] = M_OPCODE;
         end else if (tmo_fire && grant[i]) begin
            mode_nxt[i] = M_IGNORE;
         end else if (op_done[i]) begin
            case (rx_byte[i])
               OP_READ:  mode_nxt[i] = M_READ;
               OP_WRITE: mode_nxt[i] = M_WRITE;
               OP_RAM:   mode_nxt[i] = M_RAM;
               default:  mode_nxt[i] = M_IGNORE;
            endcase
         end
      end
   end

   // per-port frame mode register
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (reset) mode[i] <= M_OPCODE;
         else       mode[i] <= mode_nxt[i];
      end
   end

   // per-port shift, mailbox, request and MISO datapath
   always_ff @(posedge clk) begin
      if (reset) begin
         armed     <= '0;
         request   <= '0;
         port_miso <= '0;
         for (int i = 0; i < NUM_PORTS; i++) begin
            bit_cnt[i]  <= '0;
            shift_in[i] <= '0;
            tx_shift[i] <= '0;
            mailbox[i]  <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_PORTS; i++) begin
            if (s_nss[i]) armed[i] <= 1'b1;
            if (!rx_en[i]) begin
               // idle, aborted or ignored frame: drop any partial byte and request
               bit_cnt[i]   <= '0;
               request[i]   <= 1'b0;
               port_miso[i] <= 1'b0;
            end else begin
               if (sck_rise[i]) begin
                  shift_in[i] <= rx_byte[i][BYTE_WIDTH-2:0];
                  bit_cnt[i]  <= byte_done[i] ? '0 : bit_cnt[i] + CNT_W'(1);
               end
               if (req_set[i]) request[i] <= 1'b1;
               if (tmo_fire && grant[i]) request[i] <= 1'b0;
               if (byte_done[i] && mode[i] == M_WRITE) mailbox[i] <= rx_byte[i];
               if (op_done[i] && rx_byte[i] == OP_READ)
                  tx_shift[i] <= mailbox[(i + 1) % NUM_PORTS];
               case (mode[i])
                  M_READ: begin
                     // rotate so the sampled mailbox repeats on every byte
                     if (sck_fall[i]) begin
                        port_miso[i] <= tx_shift[i][BYTE_WIDTH-1];
                        tx_shift[i]  <= {tx_shift[i][BYTE_WIDTH-2:0], tx_shift[i][BYTE_WIDTH-1]};
                     end
                  end
                  M_RAM:   port_miso[i] <= grant[i] & ram_miso;
                  default: port_miso[i] <= 1'b0;
               endcase
            end
         end
      end
   end

   // round-robin pick; a releasing or timed-out owner has no effective request so it is skipped
   always_comb begin
      keep    = (|(grant & rx_en)) & ~tmo_fire;
      req_eff = req_set | (request & rx_en);
      if (tmo_fire) req_eff = req_eff & ~grant;
      grant_nxt = grant;
      ptr_nxt   = ptr;
      found     = 1'b0;
      if (!keep) begin
         grant_nxt = '0;
         for (int k = 0; k < NUM_PORTS; k++) begin
            if (!found && req_eff[(int'(ptr) + k) % NUM_PORTS]) begin
               found = 1'b1;
               grant_nxt[(int'(ptr) + k) % NUM_PORTS] = 1'b1;
               ptr_nxt = IDX_W'(((int'(ptr) + k) % NUM_PORTS + 1) % NUM_PORTS);
            end
         end
      end
   end

   // grant and round-robin pointer registers
   always_ff @(posedge clk) begin
      if (reset) begin
         grant <= '0;
         ptr   <= '0;
      end else begin
         grant <= grant_nxt;
         ptr   <= ptr_nxt;
      end
   end

   // RAM master pins follow the owner's synchronized pins one clk later; idle when unowned
   always_ff @(posedge clk) begin
      if (reset) begin
         ram_nss  <= 1'b1;
         ram_sck  <= 1'b0;
         ram_mosi <= 1'b0;
      end else begin
         ram_nss  <= ~keep;
         ram_sck  <= keep & (|(grant & s_sck));
         ram_mosi <= keep & (|(grant & s_mosi));
      end
   end

`ifdef SPI_RAM_ARBITER_TIMEOUT_EN
   logic [9:0] idle_cnt;
   logic       owner_edge;

   assign owner_edge = |(grant & (sck_rise | sck_fall));
   assign tmo_fire   = (|grant) & ~owner_edge & (idle_cnt == 10'd1023);

   // count owner clk cycles without an SCK edge; flag the owner when the bound is reached
   always_ff @(posedge clk) begin
      if (reset) begin
         idle_cnt     <= '0;
         timeout_flag <= '0;
      end else begin
         if (grant_nxt != grant || owner_edge || !(|grant)) idle_cnt <= '0;
         else                                               idle_cnt <= idle_cnt + 10'd1;
         for (int i = 0; i < NUM_PORTS; i++) begin
            if (tmo_fire && grant[i]) timeout_flag[i] <= 1'b1;
            else if (op_done[i])      timeout_flag[i] <= 1'b0;
         end
      end
   end
`else
   assign tmo_fire     = 1'b0;
   assign timeout_flag = '0;
`endif

endmodule

// File: doc/spi_ram_arbiter.md
SPI_RAM_ARBITER -- requirements
Module: spi_ram_arbiter

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 2: number of SPI slave ports, range 2..8.
REQ-002 SHALL have parameter BYTE_WIDTH, default 8: bits per SPI byte and mailbox width.
REQ-003 SHALL have parameter SYNC_STAGES, default 2: synchronizer flops per SPI input, range 2..3.
REQ-004 SHALL have port clk  input  1  sole clock; all logic is on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous reset, active high.
REQ-006 SHALL have port port_nss  input  NUM_PORTS  per-port active-low slave select, asynchronous to clk.
REQ-007 SHALL have port port_sck  input  NUM_PORTS  per-port SPI clock, mode 0, asynchronous to clk.
REQ-008 SHALL have port port_mosi  input  NUM_PORTS  per-port serial data in.
REQ-009 SHALL have port port_miso  output  NUM_PORTS  per-port serial data out, registered.
REQ-010 SHALL have port port_wait  output  NUM_PORTS  high while that port's RAM request is pending and not granted.
REQ-011 SHALL have port ram_nss, ram_sck, ram_mosi  output  1 each  registered serial RAM master pins.
REQ-012 SHALL have port ram_miso  input  1  serial RAM data out.
REQ-013 SHALL have port timeout_flag  output  NUM_PORTS  sticky per-port grant-timeout flags.

Function
REQ-014 SHALL pass each port_nss/sck/mosi through SYNC_STAGES flops and detect SCK edges in clk domain; operation is guaranteed only for clk >= 8x SCK frequency.
REQ-015 SHALL shift MOSI in on a detected SCK rising edge and update MISO on a detected SCK falling edge; the per-port bit counter wraps at BYTE_WIDTH.
REQ-016 SHALL treat the first complete byte of each frame (nss low) as the opcode: 0x01 READ_MAILBOX, 0x02 WRITE_MAILBOX, 0x03 ACCESS_RAM; any other opcode makes the port ignore the rest of the frame and drive port_miso 0.
REQ-017 SHALL, in WRITE_MAILBOX, commit each complete subsequent byte to the port's own mailbox; the last complete byte wins and partial bytes are discarded.
REQ-018 SHALL, in READ_MAILBOX, shift out MSB first the mailbox of port (i+1) mod NUM_PORTS, sampled at opcode completion, repeating on each byte.
REQ-019 SHALL register an ACCESS_RAM request at opcode completion; a single-owner round-robin arbiter grants the lowest-index requester at or after the last owner + 1 in the same cycle the request is registered, if the bus is free.
REQ-020 SHALL hold port_wait[i] = request_i AND NOT grant_i; it is 0 for an immediately granted request, and the master must not clock further bytes while it is high.
REQ-021 SHALL, while port i owns the bus, drive ram_nss low and register ram_sck/ram_mosi from the synchronized port i signals, giving SYNC_STAGES+1 clk pin-to-pin latency; port_miso[i] is ram_miso registered once.
REQ-022 SHALL release the grant on the cycle the owner's synchronized nss rises; ram_nss goes high and ram_sck low on the next clk; on simultaneous release and pending requests the grant passes in that cycle and the releasing port is not eligible.
REQ-023 SHALL abort a frame when nss rises mid-byte: counter cleared, no commit, request withdrawn.
REQ-024 SHALL drive ram_nss 1, ram_sck 0, ram_mosi 0 when no port owns the bus.

Reset
REQ-025 SHALL on reset clear all mailboxes, counters, requests, the grant, the round-robin pointer (next = port 0) and timeout_flag, and drive port_miso 0, port_wait 0, ram_nss 1, ram_sck 0, ram_mosi 0.
REQ-026 SHALL, after reset, ignore each port until its synchronized nss has been seen high, so frames in flight at reset are abandoned.

Configuration
REQ-027 SHALL, with macro SPI_RAM_ARBITER_TIMEOUT_EN defined, revoke a grant held for 1024 clk cycles with no owner SCK edge, force ram_nss high, set timeout_flag[owner] and ignore that port until its nss rises; the flag clears at that port's next opcode completion.
REQ-028 SHALL, without SPI_RAM_ARBITER_TIMEOUT_EN, hold grants indefinitely and tie timeout_flag to 0.

Verification
REQ-029 Port 0 sends 0x02,0xA5; port 1 then sends 0x01,0x00 -> port 1 MISO returns 0xA5 in its second byte.
REQ-030 Ports 0 and 1 complete 0x03 in the same clk after reset -> port 0 granted, port_wait = 2'b10; port 0 nss rises -> port 1 granted the same cycle, port_wait = 0.
REQ-031 Granted port sends 0x03,0x12 -> ram_sck/ram_mosi replicate the 0x12 bits SYNC_STAGES+1 clk late, ram_nss low throughout.
REQ-032 Port 0 sends 0x02 then 5 bits and raises nss -> mailbox keeps its previous value.
REQ-033 With SPI_RAM_ARBITER_TIMEOUT_EN, granted port stalls SCK for 1024 clk -> ram_nss 1, timeout_flag[0] = 1; next opcode from port 0 -> flag 0.
